divider_iterative: RTL
======================

// Module: divider_iterative
// PURPOSE
//  Iterative restoring divider; the inverse of the iterative multiplier unit.
//  Takes a 2*WIDTH-bit dividend (e.g. a multiplier product) and a WIDTH-bit divisor.
//  Returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder, resolving one quotient bit per cycle.
//  Same valid_in/valid_out pulse handshake as the multiplier; sits beside it in the functional-unit set.
// PARAMETERS
//  WIDTH  32  divisor/remainder width; dividend and quotient are 2*WIDTH
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous, active-low reset
//  valid_in   in   1          start pulse; n,d sampled on the clk edge where valid_in=1 and state=IDLE
//  n          in   2*WIDTH    dividend
//  d          in   WIDTH      divisor
//  busy       out  1          1 in RUN and DONE states
//  valid_out  out  1          one-cycle pulse; q,rem valid from this cycle on
//  q          out  2*WIDTH    quotient
//  rem        out  WIDTH      remainder
//  dbz        out  1          divide-by-zero flag (only with DIV_ZERO_DETECT_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy, valid_out, q, rem, dbz, and iteration counter all 0.
//  - FSM: IDLE -> RUN on valid_in; RUN -> DONE after 2*WIDTH iterations; DONE -> IDLE unconditionally.
//  - Capture edge E0: latch n into the shift register and d into the divisor register; clear the partial
//    remainder (WIDTH+1 bits); counter=0.
//  - RUN, each edge: shift {prem,dividend} left by 1; trial = prem - {1'b0,d}.
//    If trial >= 0, prem=trial and shift in quotient bit 1; else keep prem and shift in 0.
//    counter++.
//  - After edge E(2*WIDTH), state=DONE: valid_out=1 for exactly that cycle; q and rem registers updated on
//    that same edge. Latency: valid_out high 2*WIDTH cycles after the capture edge (64 for WIDTH=32).
//  - q and rem hold until the next DONE; they are not cleared on a new start.
//  - valid_in while busy (RUN or DONE) is ignored: no restart, no queuing. Operand changes while busy have
//    no effect.
//  - valid_in held high continuously: a new operation starts in the IDLE cycle after every DONE.
//  - Invariant: n == q*d + rem with rem < d, for all d != 0.
//  - d==0 without the feature: the algorithm runs normally and yields q=all ones, rem=n[WIDTH-1:0]
//    (the natural restoring result). Same latency; no flag.
//  - Reset asserted mid-RUN: aborts immediately and returns to IDLE. No valid_out for the aborted operation.
// CONFIGURATION
//  DIV_ZERO_DETECT_EN defined:
//   - The dbz port exists.
//   - If d==0 at capture: skip RUN and go IDLE -> DONE directly (valid_out on the edge after capture).
//   - In that case q=all ones, rem=n[WIDTH-1:0], dbz=1.
//   - dbz is updated together with q; it is 0 for nonzero d.
//  DIV_ZERO_DETECT_EN undefined:
//   - No dbz port.
//   - d==0 takes the full 2*WIDTH-cycle path with the same q/rem values.
// STRUCTURE
//  - Shared functional-unit package: typedef enum logic[1:0] {IDLE,RUN,DONE} fu_state_t (reused by the
//    multiplier); localparam ITERS = 2*WIDTH; counter width = $clog2(ITERS+1).
//  - One sub-module, div_step: combinational shift/trial-subtract/select for a single quotient bit.
//    The top holds the FSM, counter and registers.
// TESTING
//  1. Reset mid-RUN (pulse rst_n low at cycle 10 of a run) -> q=0, rem=0, busy=0; no valid_out follows.
//  2. n=100, d=7 -> valid_out exactly 64 cycles after capture; q=14, rem=2.
//  3. Sweep a=1..100, b=a: n=a*b, d=b -> q=a, rem=0 each time.
//     Then 100 steps with a+=0x23456789, b+=0x34567891, nonzero d -> q*d+rem==n, rem<d.
//  4. n=64'hFFFF_FFFF_FFFF_FFFF, d=1 -> q=all ones, rem=0.
//     Same n with d=32'hFFFF_FFFF -> q=64'h1_0000_0001, rem=0.
//  5. valid_in pulsed again at cycle 20 of a run with different operands -> ignored; original result
//     returned at cycle 64.
//  6. d=0, n=5: with DIV_ZERO_DETECT_EN -> valid_out 1 cycle after capture, dbz=1, q=all ones, rem=5.
//     Without it -> valid_out at cycle 64, same q/rem.

Source files
------------

// File: rtl/divider_iterative_pkg.sv
// Shared functional-unit definitions: the FSM state type used by the iterative units,
// plus a helper that sizes the iteration counter.
package divider_iterative_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fu_state_t;

  // The counter has to be able to hold the value iters itself.
  function automatic int unsigned cnt_width(input int unsigned iters);
    return $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/divider_iterative_div_step.sv
// One restoring-division step: shift {prem,dividend} left by one bit, trial-subtract the
// divisor, and pick the new partial remainder and quotient bit.
module divider_iterative_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]     prem,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH:0]     prem_next,
  output logic [2*WIDTH-1:0] dividend_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  always_comb begin
    shifted = {prem, dividend[2*WIDTH-1]};
    ge      = shifted >= {2'b00, d};
    // When ge holds, the difference always fits in WIDTH+1 bits.
    diff    = shifted[WIDTH:0] - {1'b0, d};
    if (ge) begin
      prem_next = diff;
    end else begin
      prem_next = shifted[WIDTH:0];
    end
    dividend_next = {dividend[2*WIDTH-2:0], ge};
  end

endmodule

// File: rtl/divider_iterative.sv
// Iterative restoring divider: 2*WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit
// per cycle. Define DIV_ZERO_DETECT_EN to add the dbz port and the divide-by-zero fast path.
module divider_iterative
  import divider_iterative_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [2*WIDTH-1:0] n,
  input  logic [WIDTH-1:0]   d,
  output logic               busy,
  output logic               valid_out,
  output logic [2*WIDTH-1:0] q,
  output logic [WIDTH-1:0]   rem
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic               dbz
`endif
);

  localparam int unsigned ITERS = 2 * WIDTH;
  localparam int unsigned CNT_W = cnt_width(ITERS);

  fu_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     prem_q, prem_d;
  logic [2*WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [2*WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     step_prem;
  logic [2*WIDTH-1:0] step_dvd;

  divider_iterative_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .prem          (prem_q),
    .dividend      (dvd_q),
    .d             (dsr_q),
    .prem_next     (step_prem),
    .dividend_next (step_dvd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          dvd_d   = n;
          dsr_d   = d;
          prem_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
          if (d == '0) begin
            state_d = DONE;
            q_d     = '1;
            rem_d   = n[WIDTH-1:0];
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        prem_d = step_prem;
        dvd_d  = step_dvd;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = DONE;
          q_d     = step_dvd;
          rem_d   = step_prem[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign valid_out = (state_q == DONE);
  assign q         = q_q;
  assign rem       = rem_q;
`ifdef DIV_ZERO_DETECT_EN
  assign dbz       = dbz_q;
`else
  // Without the fast path dbz_q is never set; it stays as plain state for a uniform datapath.
  logic unused_dbz;
  assign unused_dbz = dbz_q;
`endif

endmodule
